// File: rtl/add16u_err_monitor.sv
// Error-distance monitor for a 16-bit unsigned adder under test: counts wrong results,
// sums and tracks the largest |O - (A+B)| over a WINDOW-sample window. Optional ADD16U_ERR_MON_SQERR_EN adds sum_sq.
module add16u_err_monitor #(
    parameter logic [15:0] WINDOW = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [16:0] O,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic [39:0] sum_ed,
    output logic [16:0] max_ed,
    output logic [1:0]  dbg_state
`ifdef ADD16U_ERR_MON_SQERR_EN
    ,
    output logic [55:0] sum_sq
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic        flush_cnt;
    logic        s1_valid;
    logic [16:0] s1_exact;
    logic [16:0] s1_o;
    logic        accept;
    logic        ed_neg;
    logic [16:0] ed;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready is high only in RUN.
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Magnitude of the 18-bit signed difference; it always fits in 17 bits.
    assign ed_neg = (s1_o < s1_exact);
    assign ed     = ed_neg ? (s1_exact - s1_o) : (s1_o - s1_exact);

`ifdef ADD16U_ERR_MON_SQERR_EN
    logic [33:0] ed_sq;
    assign ed_sq = 34'(ed) * 34'(ed);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            flush_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_o      <= '0;
            err_cnt   <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
`ifdef ADD16U_ERR_MON_SQERR_EN
            sum_sq    <= '0;
`endif
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_exact <= {1'b0, A} + {1'b0, B};
                s1_o     <= O;
            end

            if (s1_valid) begin
                err_cnt <= err_cnt + {15'd0, (ed != 17'd0)};
                sum_ed  <= sum_ed + {23'd0, ed};
                if (ed > max_ed) begin
                    max_ed <= ed;
                end
`ifdef ADD16U_ERR_MON_SQERR_EN
                sum_sq  <= sum_sq + {22'd0, ed_sq};
`endif
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Later assignments override the accumulate above on this edge.
                        state    <= RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        count    <= '0;
                        s1_valid <= 1'b0;
                        err_cnt  <= '0;
                        sum_ed   <= '0;
                        max_ed   <= '0;
`ifdef ADD16U_ERR_MON_SQERR_EN
                        sum_sq   <= '0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count + 16'd1;
                        if (count == WINDOW - 16'd1) begin
                            state     <= FLUSH;
                            in_ready  <= 1'b0;
                            flush_cnt <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Bench for add16u_err_monitor: four instances (WINDOW 4, 3, 1, 8) driven from a table of
// directed windows with hand-computed results, plus reset and restart sequences.
module tb_add16u_err_monitor;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] o;
    } sample_t;

    typedef struct packed {
        logic [1:0]        inst;
        logic [3:0]        n;
        logic              gappy;
        sample_t [7:0]     s;
        logic [15:0]       e_err;
        logic [39:0]       e_sum;
        logic [16:0]       e_max;
        logic [55:0]       e_sq;
    } case_t;

    logic        clk;
    logic        rst_n;
    logic        start_v  [4];
    logic        valid_v  [4];
    logic        ready_v  [4];
    logic [15:0] a_v      [4];
    logic [15:0] b_v      [4];
    logic [16:0] o_v      [4];
    logic        busy_v   [4];
    logic        done_v   [4];
    logic [15:0] err_v    [4];
    logic [39:0] sum_v    [4];
    logic [16:0] max_v    [4];
    logic [1:0]  st_v     [4];
    logic [55:0] sq_v     [4];

    int    checks;
    int    errors;
    case_t cases [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic [15:0] WIN = (g == 0) ? 16'd4 : (g == 1) ? 16'd3 : (g == 2) ? 16'd1 : 16'd8;
        add16u_err_monitor #(.WINDOW(WIN)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .in_valid  (valid_v[g]),
            .in_ready  (ready_v[g]),
            .A         (a_v[g]),
            .B         (b_v[g]),
            .O         (o_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .err_cnt   (err_v[g]),
            .sum_ed    (sum_v[g]),
            .max_ed    (max_v[g]),
            .dbg_state (st_v[g])
`ifdef ADD16U_ERR_MON_SQERR_EN
            ,
            .sum_sq    (sq_v[g])
`endif
        );
`ifndef ADD16U_ERR_MON_SQERR_EN
        assign sq_v[g] = '0;
`endif
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_sample(input int c, input int k, input logic [15:0] a,
                              input logic [15:0] b, input logic [16:0] o);
        cases[c].s[k] = {a, b, o};
    endtask

    task automatic check_results(input string tag, input int idx, input case_t cs);
        check({tag, " err_cnt"}, 64'(err_v[idx]), 64'(cs.e_err));
        check({tag, " sum_ed"},  64'(sum_v[idx]), 64'(cs.e_sum));
        check({tag, " max_ed"},  64'(max_v[idx]), 64'(cs.e_max));
`ifdef ADD16U_ERR_MON_SQERR_EN
        check({tag, " sum_sq"},  64'(sq_v[idx]),  64'(cs.e_sq));
`endif
    endtask

    task automatic pulse_start(input int idx);
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        check("start state_run", 64'(st_v[idx]), 64'd1);
        check("start busy", 64'(busy_v[idx]), 64'd1);
        check("start err_cnt_clr", 64'(err_v[idx]), 64'd0);
        check("start sum_ed_clr", 64'(sum_v[idx]), 64'd0);
        check("start max_ed_clr", 64'(max_v[idx]), 64'd0);
    endtask

    task automatic run_case(input int c);
        case_t cs;
        int    idx;
        int    k;
        int    cyc;
        logic  toggle;
        logic  drive;
        logic  accepted;
        cs = cases[c];
        idx = int'(cs.inst);
        pulse_start(idx);
        k = 0;
        cyc = 0;
        toggle = 1'b0;
        while (k < int'(cs.n) && cyc < 100) begin
            cyc++;
            drive = !(cs.gappy && toggle);
            valid_v[idx] = drive;
            {a_v[idx], b_v[idx], o_v[idx]} = cs.s[k];
            // Stray start mid-window must not restart the count.
            start_v[idx] = cs.gappy && (k == 3) && !drive;
            toggle = !toggle;
            accepted = valid_v[idx] && ready_v[idx];
            @(posedge clk); #1;
            if (accepted) k++;
        end
        start_v[idx] = 1'b0;
        check("window accepts", 64'(k), 64'(cs.n));
        // Junk offered during FLUSH must be refused.
        valid_v[idx] = 1'b1;
        {a_v[idx], b_v[idx], o_v[idx]} = {16'd0, 16'd0, 17'h1FFFF};
        start_v[idx] = cs.gappy;
        check("flush state", 64'(st_v[idx]), 64'd2);
        check("flush ready", 64'(ready_v[idx]), 64'd0);
        check("flush done", 64'(done_v[idx]), 64'd0);
        check("flush busy", 64'(busy_v[idx]), 64'd1);
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        check("flush2 done", 64'(done_v[idx]), 64'd0);
        @(posedge clk); #1;
        check("done rise", 64'(done_v[idx]), 64'd1);
        check("done busy", 64'(busy_v[idx]), 64'd0);
        check("done ready", 64'(ready_v[idx]), 64'd0);
        check("done state", 64'(st_v[idx]), 64'd3);
        check_results("done", idx, cs);
        repeat (2) @(posedge clk);
        #1;
        valid_v[idx] = 1'b0;
        check("hold done", 64'(done_v[idx]), 64'd1);
        check_results("hold", idx, cs);
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst state", 64'(st_v[idx]), 64'd0);
        check("rst ready", 64'(ready_v[idx]), 64'd0);
        check("rst busy", 64'(busy_v[idx]), 64'd0);
        check("rst done", 64'(done_v[idx]), 64'd0);
        check("rst err_cnt", 64'(err_v[idx]), 64'd0);
        check("rst sum_ed", 64'(sum_v[idx]), 64'd0);
        check("rst max_ed", 64'(max_v[idx]), 64'd0);
        check("rst sum_sq", 64'(sq_v[idx]), 64'd0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            valid_v[i] = 1'b0;
            a_v[i] = '0;
            b_v[i] = '0;
            o_v[i] = '0;
        end

        // Case table: inputs and hand-computed expected results.
        for (int c = 0; c < 5; c++) cases[c] = '0;
        // WINDOW=4 with errors: ED 1, 4, 0, 131071.
        cases[0].inst = 2'd0; cases[0].n = 4'd4;
        set_sample(0, 0, 16'd1, 16'd1, 17'd3);
        set_sample(0, 1, 16'd2, 16'd2, 17'd0);
        set_sample(0, 2, 16'hFFFF, 16'd0, 17'h0FFFF);
        set_sample(0, 3, 16'd0, 16'd0, 17'h1FFFF);
        cases[0].e_err = 16'd3; cases[0].e_sum = 40'd131076;
        cases[0].e_max = 17'd131071; cases[0].e_sq = 56'd17179607058;
        // WINDOW=4 exact adder, random operands.
        cases[1].inst = 2'd0; cases[1].n = 4'd4;
        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            set_sample(1, k, ra, rb, {1'b0, ra} + {1'b0, rb});
        end
        // WINDOW=3: ED 0, 2, 3.
        cases[2].inst = 2'd1; cases[2].n = 4'd3;
        set_sample(2, 0, 16'hFFFF, 16'd1, 17'h10000);
        set_sample(2, 1, 16'd5, 16'd5, 17'd8);
        set_sample(2, 2, 16'd0, 16'd0, 17'd3);
        cases[2].e_err = 16'd2; cases[2].e_sum = 40'd5; cases[2].e_max = 17'd3; cases[2].e_sq = 56'd13;
        // WINDOW=1: largest negative difference.
        cases[3].inst = 2'd2; cases[3].n = 4'd1;
        set_sample(3, 0, 16'hFFFF, 16'hFFFF, 17'd0);
        cases[3].e_err = 16'd1; cases[3].e_sum = 40'd131070;
        cases[3].e_max = 17'h1FFFE; cases[3].e_sq = 56'd17179344900;
        // WINDOW=8 with gaps and a stray start: ED 0,2,1,15,0,0,16,3.
        cases[4].inst = 2'd3; cases[4].n = 4'd8; cases[4].gappy = 1'b1;
        set_sample(4, 0, 16'd10, 16'd20, 17'd30);
        set_sample(4, 1, 16'd100, 16'd1, 17'd99);
        set_sample(4, 2, 16'hFFFF, 16'hFFFF, 17'h1FFFF);
        set_sample(4, 3, 16'd7, 16'd8, 17'd0);
        set_sample(4, 4, 16'd1000, 16'd2000, 17'd3000);
        set_sample(4, 5, 16'd0, 16'd0, 17'd0);
        set_sample(4, 6, 16'h8000, 16'h8000, 17'h10010);
        set_sample(4, 7, 16'd3, 16'd4, 17'd10);
        cases[4].e_err = 16'd5; cases[4].e_sum = 40'd37; cases[4].e_max = 17'd16; cases[4].e_sq = 56'd495;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_reset_outputs(i);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Errorful window then restart from DONE into a clean window.
        for (int c = 0; c < 5; c++) run_case(c);

        // Reset after two of four samples discards the window.
        pulse_start(0);
        valid_v[0] = 1'b1;
        {a_v[0], b_v[0], o_v[0]} = {16'd1, 16'd1, 17'd3};
        @(posedge clk); #1;
        {a_v[0], b_v[0], o_v[0]} = {16'd2, 16'd2, 17'd0};
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        @(posedge clk); #1;
        check("mid live err_cnt", 64'(err_v[0]), 64'd2);
        check("mid live sum_ed", 64'(sum_v[0]), 64'd5);
        check("mid state", 64'(st_v[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs(0);
        run_case(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
